// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle for the shared-ALU arbiter.
// master: requesters and consumer; slave: the arbiter.
interface alu_share_arbiter_if #(
  parameter int CNT_W = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [31:0]      req0_a;
  logic [31:0]      req0_b;
  logic [2:0]       req0_sel;
  logic             req1_valid;
  logic             req1_ready;
  logic [31:0]      req1_a;
  logic [31:0]      req1_b;
  logic [2:0]       req1_sel;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_y;
  logic             rsp_nz;
  logic             rsp_id;
  logic [CNT_W-1:0] gnt_cnt0;
  logic [CNT_W-1:0] gnt_cnt1;

  modport master (
    output req0_valid, req0_a, req0_b, req0_sel,
    output req1_valid, req1_a, req1_b, req1_sel,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_y, rsp_nz, rsp_id,
    input  gnt_cnt0, gnt_cnt1
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sel,
    input  req1_valid, req1_a, req1_b, req1_sel,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_y, rsp_nz, rsp_id,
    output gnt_cnt0, gnt_cnt1
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one 32-bit ALU between two requesters,
// with a single registered response slot and per-port grant counters.
module alu_share_arbiter #(
  parameter int CNT_W = 16
) (
  input logic                clk,
  input logic                rst_n,
  alu_share_arbiter_if.slave bus
);

  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_y_q, rsp_y_d;
  logic             rsp_nz_q, rsp_nz_d;
  logic             rsp_id_q, rsp_id_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic        slot_free;
  logic        gnt0, gnt1, gnt_any;
  logic [31:0] op_a, op_b, alu_y;
  logic [2:0]  op_sel;
  logic        alu_nz;

  // last_q=1 favours port 0 on the next contended cycle
  assign slot_free = !rsp_valid_q || bus.rsp_ready;
  assign gnt0 = slot_free && bus.req0_valid
             && (!bus.req1_valid || last_q);
  assign gnt1 = slot_free && bus.req1_valid
             && (!bus.req0_valid || !last_q);
  assign gnt_any = gnt0 || gnt1;

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;

  assign op_a   = gnt1 ? bus.req1_a   : bus.req0_a;
  assign op_b   = gnt1 ? bus.req1_b   : bus.req0_b;
  assign op_sel = gnt1 ? bus.req1_sel : bus.req0_sel;

  always_comb begin
    alu_y = 32'd0;
    unique case (op_sel)
      3'b000: alu_y = op_a + op_b;
      3'b001: alu_y = op_a - op_b;
      3'b010: alu_y = op_a & op_b;
      3'b011: alu_y = op_a | op_b;
      3'b100: alu_y = op_a ^ op_b;
      3'b101: alu_y = ~(op_a | op_b);
      3'b110: alu_y = {31'd0, $signed(op_a) < $signed(op_b)};
      3'b111: alu_y = op_a + op_b;
    endcase
  end

  assign alu_nz = |alu_y;

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_y_d     = rsp_y_q;
    rsp_nz_d    = rsp_nz_q;
    rsp_id_d    = rsp_id_q;
    last_d      = last_q;
    cnt0_d      = cnt0_q;
    cnt1_d      = cnt1_q;
    if (gnt_any) begin
      rsp_valid_d = 1'b1;
      rsp_y_d     = alu_y;
      rsp_nz_d    = alu_nz;
      rsp_id_d    = gnt1;
      last_d      = gnt1;
      if (gnt0) cnt0_d = cnt0_q + CNT_W'(1);
      if (gnt1) cnt1_d = cnt1_q + CNT_W'(1);
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_y_q     <= 32'd0;
      rsp_nz_q    <= 1'b0;
      rsp_id_q    <= 1'b0;
      last_q      <= 1'b1;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_y_q     <= rsp_y_d;
      rsp_nz_q    <= rsp_nz_d;
      rsp_id_q    <= rsp_id_d;
      last_q      <= last_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_y     = rsp_y_q;
  assign bus.rsp_nz    = rsp_nz_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.gnt_cnt0  = cnt0_q;
  assign bus.gnt_cnt1  = cnt1_q;

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-port arbiter that time-shares one 32-bit ALU instance between two requesters, for example the EX stage and a branch/address-compare unit. Each requester presents operands and a 3-bit op-select with a valid/ready handshake. The block grants one request per cycle using round-robin, registers the ALU result into a single response slot tagged with the requester ID, and applies backpressure when the slot is full. It also keeps per-port grant counters for performance monitoring.

## Interface
- CNT_W, default 16: width of each per-port grant counter.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- req0_valid  in  1  port 0 request valid.
- req0_ready  out  1  port 0 request accepted this cycle (combinational).
- req0_a, req0_b  in  32 each  port 0 operands.
- req0_sel  in  3  port 0 ALU op-select.
- req1_valid, req1_ready, req1_a, req1_b, req1_sel: same as port 0, for port 1.
- rsp_valid  out  1  response slot holds a result.
- rsp_ready  in  1  consumer takes the response this cycle.
- rsp_y  out  32  registered ALU result.
- rsp_nz  out  1  registered ALU flag: 1 when the result is nonzero.
- rsp_id  out  1  requester that produced the response (0 or 1).
- gnt_cnt0, gnt_cnt1  out  CNT_W each  accepted-request counts for port 0 and port 1.

## Operation
- Shared ALU op-select encoding:
  - 000 add, 001 sub (a−b), 010 and, 011 or, 100 xor, 101 nor.
  - 110 slt: signed compare, y=1 when a<b as two's complement, else 0.
  - 111 add.
  - All arithmetic is 32-bit modulo; no carry or overflow output.
- ALU flag polarity: the ALU asserts its flag when y≠0. The block forwards it unchanged as rsp_nz and does not invert it.
- Slot free condition: slot_free = !rsp_valid || rsp_ready.
- Arbitration, when slot_free:
  - Only one port valid: grant it.
  - Both ports valid: grant the port that does not match the round-robin pointer `last`.
  - Neither port valid: no grant.
  - When slot_free=0, neither reqN_ready is asserted.
- reqN_ready equals grantN. It depends on reqN_valid, rsp_valid, rsp_ready and `last` only. It never depends on operands or op-select.
- On a grant, the muxed operands and op-select of the granted port drive the ALU. At the clock edge:
  - rsp_y and rsp_nz load the ALU outputs.
  - rsp_id loads the granted port number.
  - rsp_valid is set to 1.
  - `last` is set to the granted port.
  - gnt_cntN of the granted port increments by 1, modulo 2^CNT_W (wraps to 0 with no saturation).
- Response handshake:
  - Consumed with no new grant (rsp_valid & rsp_ready): rsp_valid clears to 0. rsp_y, rsp_nz and rsp_id hold their old values.
  - Consumed with a new grant in the same cycle: the slot reloads back-to-back and rsp_valid stays 1.
- Requesters hold valid, operands and op-select stable until ready is asserted. The block does not register unaccepted requests.
- Reset values:
  - rsp_valid 0, rsp_y 0, rsp_nz 0, rsp_id 0.
  - gnt_cnt0 0, gnt_cnt1 0.
  - `last` = 1, so port 0 wins the first contended cycle.

## Timing
- Latency: a request accepted in cycle N has its result on rsp_* in cycle N+1.
- Throughput: 1 op/cycle aggregate while rsp_ready is held high.
- Under continuous contention, grants alternate 0,1,0,1…, and each port gets 1 op every 2 cycles. No port is starved for more than 1 cycle while the slot is free.
- While rsp_ready=0 and rsp_valid=1, all rsp_* outputs are stable and both req ready signals are 0.
- Reset is asynchronous: assertion clears all state immediately, including a response in flight, which is dropped. The first grant is possible on the first rising edge after rst_n deasserts.
- No combinational path from rsp_ready to rsp_*. rsp_ready reaches reqN_ready combinationally.

## Test plan
- Single request: port 0 with a=5, b=7, sel=000, rsp_ready=1, accepted in cycle N. In cycle N+1: rsp_valid=1, rsp_y=12, rsp_nz=1, rsp_id=0, gnt_cnt0=1.
- Contention after reset: both ports valid continuously, with port 0 sel=001 a=3 b=3 and port 1 sel=110 a=0xFFFFFFFF b=1.
  - Responses alternate id 0,1,0,1.
  - Id 0 responses: rsp_y=0, rsp_nz=0.
  - Id 1 responses: rsp_y=1, rsp_nz=1.
- Backpressure: hold rsp_ready=0 for 3 cycles with both ports valid.
  - rsp_* stay frozen and req0_ready = req1_ready = 0.
  - Raise rsp_ready: the next grant loads back-to-back with rsp_valid staying 1.
- Op coverage: sel 000–111 with a=0xF0F0F0F0, b=0x0FF00FF0.
  - Results in sel order: 0x00E100E0, 0xE100E100, 0x00F000F0, 0xFFF0FFF0, 0xFF00FF00, 0x000F000F, 1, 0x00E100E0.
- Counter wrap: CNT_W=4, 17 grants to port 1, so gnt_cnt1=1 and gnt_cnt0=0.
- Reset mid-operation: assert rst_n low while rsp_valid=1 and rsp_ready=0.
  - All outputs go to reset values without waiting for a clock edge.
  - After release, a contended first cycle grants port 0.
